dot_product_mac: RTL and testbench

Multiply-accumulate stage that sits directly downstream of `mem_reader` in the dotProduct datapath. On a `start` request it pulses `start_reading` to the reader. It then consumes `VECTOR_WIDTH` operand pairs (`mem1_output`, `mem2_output`) qualified by `data_valid` and accumulates their products through a two-stage multiply/add pipeline. It presents the final dot product on a valid/ready result port.

---
 rtl/dot_product_mac.sv | 190 +++++++++++++++++++
 tb/tb_dot_product_mac.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_mac.sv
// -----------------------------------------------------------------------------
// dot_product_mac
//
// Multiply-accumulate stage that follows mem_reader in the dotProduct
// datapath. A start request makes this block pulse start_reading to the
// reader. It then accepts VECTOR_WIDTH operand pairs and sums their products
// through a two-stage pipeline: stage 1 registers the product, stage 2 adds it
// to the accumulator. The final sum is offered on a valid/ready result port.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   synchronous, active-low reset
//   start          in   request a new dot product (sampled only when idle)
//   start_reading  out  one-cycle pulse asking mem_reader to begin
//   data_valid     in   mem1_output/mem2_output carry a valid pair
//   reading_done   in   reader has finished sending pairs
//   mem1_output    in   operand A
//   mem2_output    in   operand B
//   result         out  dot product, stable while result_valid is high
//   result_valid   out  result is available
//   result_ready   in   consumer takes the result
//   busy           out  high whenever the block is not idle
//   count_err      out  sticky: reader finished before VECTOR_WIDTH pairs
// -----------------------------------------------------------------------------
module dot_product_mac #(
  parameter int DATA_WIDTH   = 8,
  parameter int VECTOR_WIDTH = 4,
  parameter int ACC_WIDTH    = 2 * DATA_WIDTH + $clog2(VECTOR_WIDTH),
  parameter bit SIGNED       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  start_reading,
  input  logic                  data_valid,
  input  logic                  reading_done,
  input  logic [DATA_WIDTH-1:0] mem1_output,
  input  logic [DATA_WIDTH-1:0] mem2_output,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy,
  output logic                  count_err
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  // Wide enough to hold both the full product and the accumulator, so that
  // the product can be extended first and then cut to ACC_WIDTH if needed.
  localparam int EXT_WIDTH  = (ACC_WIDTH > PROD_WIDTH) ? ACC_WIDTH : PROD_WIDTH;
  localparam int CNT_WIDTH  = $clog2(VECTOR_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(VECTOR_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ACCUM,
    S_FLUSH,
    S_HOLD
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]   prod_q, prod_d;
  logic                   prod_vld_q, prod_vld_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ACC_WIDTH-1:0]   result_q, result_d;
  logic                   count_err_q, count_err_d;

  logic                   accept;
  logic [PROD_WIDTH-1:0]  op_a_ext;
  logic [PROD_WIDTH-1:0]  op_b_ext;
  logic [PROD_WIDTH-1:0]  prod_full;
  logic [EXT_WIDTH-1:0]   prod_ext;
  logic [ACC_WIDTH-1:0]   pending;
  logic [ACC_WIDTH-1:0]   sum;

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
      count_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      count_err_q <= count_err_d;
    end
  end

  // Next-state logic. An early reading_done wins over a pair presented in
  // the same cycle, so such a pair is never counted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_REQ;
      S_REQ:   state_d = S_ACCUM;
      S_ACCUM: begin
        if (reading_done) begin
          state_d = S_FLUSH;
        end else if (data_valid && (cnt_q == LAST_CNT)) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_HOLD;
      S_HOLD:  if (result_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    start_reading = (state_q == S_REQ);
    busy          = (state_q != S_IDLE);
    result_valid  = (state_q == S_HOLD);
    result        = result_q;
    count_err     = count_err_q;
  end

  // Operand and product extension. The product is taken at 2*DATA_WIDTH
  // bits, whose low half is the same for signed and unsigned operands once
  // they have been extended correctly; only the final widening differs.
  always_comb begin
    if (SIGNED) begin
      op_a_ext  = PROD_WIDTH'($signed(mem1_output));
      op_b_ext  = PROD_WIDTH'($signed(mem2_output));
      prod_full = op_a_ext * op_b_ext;
      prod_ext  = EXT_WIDTH'($signed(prod_full));
    end else begin
      op_a_ext  = PROD_WIDTH'(mem1_output);
      op_b_ext  = PROD_WIDTH'(mem2_output);
      prod_full = op_a_ext * op_b_ext;
      prod_ext  = EXT_WIDTH'(prod_full);
    end
  end

  // Accumulate datapath. A pending stage-1 product is folded into the
  // accumulator on the following ACCUM or FLUSH cycle; the sum wraps at
  // ACC_WIDTH bits.
  always_comb begin
    accept      = (state_q == S_ACCUM) && data_valid && !reading_done;
    pending     = prod_vld_q ? prod_q : '0;
    sum         = acc_q + pending;

    cnt_d       = cnt_q;
    prod_d      = prod_q;
    prod_vld_d  = prod_vld_q;
    acc_d       = acc_q;
    result_d    = result_q;
    count_err_d = count_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d       = '0;
          prod_d      = '0;
          prod_vld_d  = 1'b0;
          acc_d       = '0;
          count_err_d = 1'b0;
        end
      end
      S_ACCUM: begin
        acc_d      = sum;
        prod_vld_d = accept;
        if (accept) begin
          prod_d = prod_ext[ACC_WIDTH-1:0];
          cnt_d  = cnt_q + CNT_WIDTH'(1);
        end
        if (reading_done) begin
          count_err_d = 1'b1;
        end
      end
      S_FLUSH: begin
        acc_d      = sum;
        prod_vld_d = 1'b0;
        result_d   = sum;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_dot_product_mac.sv
// -----------------------------------------------------------------------------
// tb_dot_product_mac
//
// Drives an unsigned and a signed instance of dot_product_mac with the same
// directed operand vectors. A reference sum is built with plain integer
// arithmetic per instance, and a per-cycle compare process checks every
// output against the expected protocol state. Hand-computed literals pin the
// reference results of the key vectors.
// -----------------------------------------------------------------------------
module tb_dot_product_mac;

  localparam int DW = 8;
  localparam int VW = 4;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          data_valid;
  logic          reading_done;
  logic          result_ready;
  logic [DW-1:0] mem1_output;
  logic [DW-1:0] mem2_output;

  logic          sr_u, rv_u, busy_u, err_u;
  logic [AW-1:0] res_u;
  logic          sr_s, rv_s, busy_s, err_s;
  logic [AW-1:0] res_s;

  int            n_vec     = 0;
  int            n_miscmp  = 0;
  bit            chk_en    = 1'b0;

  logic          exp_sr;
  logic          exp_busy;
  logic          exp_valid;
  logic          exp_err;
  logic [AW-1:0] exp_res_u;
  logic [AW-1:0] exp_res_s;

  int            sum_u;
  int            sum_s;
  logic [DW-1:0] a_vec [VW];
  logic [DW-1:0] b_vec [VW];

  always #5 clk = ~clk;

  dot_product_mac #(
    .DATA_WIDTH  (DW),
    .VECTOR_WIDTH(VW),
    .ACC_WIDTH   (AW),
    .SIGNED      (1'b0)
  ) dut_u (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .start_reading(sr_u),
    .data_valid   (data_valid),
    .reading_done (reading_done),
    .mem1_output  (mem1_output),
    .mem2_output  (mem2_output),
    .result       (res_u),
    .result_valid (rv_u),
    .result_ready (result_ready),
    .busy         (busy_u),
    .count_err    (err_u)
  );

  dot_product_mac #(
    .DATA_WIDTH  (DW),
    .VECTOR_WIDTH(VW),
    .ACC_WIDTH   (AW),
    .SIGNED      (1'b1)
  ) dut_s (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .start_reading(sr_s),
    .data_valid   (data_valid),
    .reading_done (reading_done),
    .mem1_output  (mem1_output),
    .mem2_output  (mem2_output),
    .result       (res_s),
    .result_valid (rv_s),
    .result_ready (result_ready),
    .busy         (busy_s),
    .count_err    (err_s)
  );

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of both instances against the expected protocol state.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("start_reading_u", 32'(sr_u),   32'(exp_sr));
      checkOutput("start_reading_s", 32'(sr_s),   32'(exp_sr));
      checkOutput("busy_u",          32'(busy_u), 32'(exp_busy));
      checkOutput("busy_s",          32'(busy_s), 32'(exp_busy));
      checkOutput("result_valid_u",  32'(rv_u),   32'(exp_valid));
      checkOutput("result_valid_s",  32'(rv_s),   32'(exp_valid));
      checkOutput("count_err_u",     32'(err_u),  32'(exp_err));
      checkOutput("count_err_s",     32'(err_s),  32'(exp_err));
      if (exp_valid) begin
        checkOutput("result_u", 32'(res_u), 32'(exp_res_u));
        checkOutput("result_s", 32'(res_s), 32'(exp_res_s));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: integer dot product under both operand interpretations.
  task automatic addPair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    sum_u += int'(a) * int'(b);
    sum_s += int'($signed(a)) * int'($signed(b));
  endtask

  // One full transaction. early < VW raises reading_done after that many
  // pairs; abort_after < VW resets the block after that many pairs.
  // A negative literal skips that literal check.
  task automatic applyStimulus(input int gapped, input int early,
                               input int hold_wait, input int start_in_hold,
                               input int abort_after,
                               input int lit_u, input int lit_s);
    sum_u        = 0;
    sum_s        = 0;
    result_ready = 1'b0;
    start        = 1'b1;
    step();
    exp_sr    = 1'b1;
    exp_busy  = 1'b1;
    exp_err   = 1'b0;
    exp_valid = 1'b0;
    start       = 1'b0;
    data_valid  = 1'b1;
    mem1_output = 8'hEE;
    mem2_output = 8'hEE;
    step();
    exp_sr = 1'b0;
    for (int i = 0; i < VW; i++) begin
      if (i == abort_after) begin
        rst_n      = 1'b0;
        data_valid = 1'b0;
        step();
        exp_busy  = 1'b0;
        exp_err   = 1'b0;
        exp_valid = 1'b0;
        rst_n     = 1'b1;
        checkOutput("result_after_reset_u", 32'(res_u), 32'h0);
        checkOutput("result_after_reset_s", 32'(res_s), 32'h0);
        step();
        return;
      end
      if (i == early) begin
        data_valid   = 1'b1;
        mem1_output  = 8'h7F;
        mem2_output  = 8'h7F;
        reading_done = 1'b1;
        step();
        reading_done = 1'b0;
        exp_err      = 1'b1;
        break;
      end
      data_valid  = 1'b1;
      mem1_output = a_vec[i];
      mem2_output = b_vec[i];
      addPair(a_vec[i], b_vec[i]);
      step();
      if ((gapped != 0) && (i < VW - 1)) begin
        data_valid  = 1'b0;
        mem1_output = 8'h55;
        mem2_output = 8'h55;
        step();
      end
    end
    // Flush cycle: an extra pair offered here must be dropped.
    data_valid  = 1'b1;
    mem1_output = 8'hFF;
    mem2_output = 8'hFF;
    step();
    data_valid = 1'b0;
    exp_valid  = 1'b1;
    exp_res_u  = AW'(sum_u);
    exp_res_s  = AW'(sum_s);
    if (lit_u >= 0) checkOutput("literal_result_u", 32'(res_u), 32'(lit_u));
    if (lit_s >= 0) checkOutput("literal_result_s", 32'(res_s), 32'(lit_s));
    for (int k = 0; k < hold_wait; k++) begin
      start = (start_in_hold != 0) && (k == 1);
      step();
    end
    start        = 1'b0;
    result_ready = 1'b1;
    step();
    exp_valid    = 1'b0;
    exp_busy     = 1'b0;
    result_ready = 1'b0;
  endtask

  task automatic loadGolden();
    a_vec = '{8'h11, 8'h12, 8'h13, 8'h14};
    b_vec = '{8'h21, 8'h22, 8'h23, 8'h24};
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    data_valid   = 1'b0;
    reading_done = 1'b0;
    result_ready = 1'b0;
    mem1_output  = '0;
    mem2_output  = '0;
    exp_sr       = 1'b0;
    exp_busy     = 1'b0;
    exp_valid    = 1'b0;
    exp_err      = 1'b0;
    exp_res_u    = '0;
    exp_res_s    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    checkOutput("reset_result_u", 32'(res_u), 32'h0);
    checkOutput("reset_result_s", 32'(res_s), 32'h0);
    step();

    // Unsigned golden run.
    loadGolden();
    applyStimulus(0, VW, 0, 0, VW, 32'h9FE, 32'h9FE);

    // All-ones operands with gaps between pairs.
    a_vec = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    b_vec = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    applyStimulus(1, VW, 0, 0, VW, 260100, 4);

    // Signed corner operands.
    a_vec = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    b_vec = '{8'h80, 8'h80, 8'h80, 8'h80};
    applyStimulus(0, VW, 0, 0, VW, 130560, 512);
    a_vec = '{8'h80, 8'h80, 8'h80, 8'h80};
    b_vec = '{8'h80, 8'h80, 8'h80, 8'h80};
    applyStimulus(0, VW, 0, 0, VW, 65536, 65536);

    // Backpressure with a start pulse that must be ignored.
    loadGolden();
    applyStimulus(0, VW, 5, 1, VW, 32'h9FE, 32'h9FE);

    // Reader finishes after two pairs.
    applyStimulus(0, 2, 0, 0, VW, 32'h495, 32'h495);

    // Next run clears count_err.
    applyStimulus(0, VW, 0, 0, VW, 32'h9FE, 32'h9FE);

    // Reset in the middle of accumulation, then a clean run.
    applyStimulus(0, VW, 0, 0, 2, -1, -1);
    applyStimulus(0, VW, 0, 0, VW, 32'h9FE, 32'h9FE);

    step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
